// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared definitions for the fetch/decode front-end sequencer:
//   default parameter values and the controller state encoding.
package pipeline_ctrl_pkg;

  localparam int DEFAULT_REGISTERS_BANK_SIZE = 32;
  localparam int DEFAULT_DRAIN_CYCLES        = 3;
  localparam int DEFAULT_COUNTER_SIZE        = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detector.sv
// pipeline_ctrl_hazard_detector
//   Purely combinational hazard detection for the instruction in ID.
//   Ports:
//     id_rs, id_rt     source registers of the ID instruction
//     id_uses_rs_id    ID instruction reads bus_a inside ID (jr/jalr/branch)
//     ex_mem_read      EX instruction is a load
//     ex_reg_write     EX instruction writes a register
//     ex_wr_addr       EX destination register
//     mem_mem_read     MEM instruction is a load
//     mem_wr_addr      MEM destination register
//     load_use         EX load feeds rs/rt of ID
//     id_dep           ID-resolved operand not yet available
//     hazard           load_use | id_dep
module pipeline_ctrl_hazard_detector
  import pipeline_ctrl_pkg::*;
#(
  parameter int REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
  localparam int AW = $clog2(REGISTERS_BANK_SIZE)
) (
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rs_id,
  input  logic          ex_mem_read,
  input  logic          ex_reg_write,
  input  logic [AW-1:0] ex_wr_addr,
  input  logic          mem_mem_read,
  input  logic [AW-1:0] mem_wr_addr,
  output logic          load_use,
  output logic          id_dep,
  output logic          hazard
);

  // Register 0 is hard-wired, so a producer targeting it never blocks anyone.
  logic ex_dst_valid;
  logic mem_dst_valid;
  logic ex_hits_rs;
  logic ex_hits_rt;
  logic mem_hits_rs;

  assign ex_dst_valid  = (ex_wr_addr != '0);
  assign mem_dst_valid = (mem_wr_addr != '0);
  assign ex_hits_rs    = ex_dst_valid  && (ex_wr_addr == id_rs);
  assign ex_hits_rt    = ex_dst_valid  && (ex_wr_addr == id_rt);
  assign mem_hits_rs   = mem_dst_valid && (mem_wr_addr == id_rs);

  assign load_use = ex_mem_read && (ex_hits_rs || ex_hits_rt);

  // Operands consumed in ID cannot use the EX/MEM forwarding paths, so any
  // EX result, and a MEM load result, must be waited for.
  assign id_dep = id_uses_rs_id &&
                  ((ex_reg_write && ex_hits_rs) || (mem_mem_read && mem_hits_rs));

  assign hazard = load_use || id_dep;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Front-end sequencer: each cycle chooses run, stall, flush or freeze,
//   handles the halt/drain sequence and debug single-step, and keeps
//   advanced-cycle and bubble-cycle counters.
//   Ports:
//     i_clk, i_reset            clock, synchronous active-high reset
//     i_step_mode, i_step       debug stepping (advance only on i_step)
//     i_id_*                    decode-stage operands, jump and halt flags
//     i_ex_*, i_mem_*           producer info from EX and MEM
//     o_pc_write, o_if_id_write PC and IF/ID load enables
//     o_if_id_flush             clear IF/ID to NOP
//     o_ctr_reg_src             1: ID emits an all-zero control bubble
//     o_pipe_enable             enable for ID/EX, EX/MEM, MEM/WB
//     o_halted                  halted and drained
//     o_cycle_count             advanced cycles since reset
//     o_stall_count             bubble cycles since reset
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
  parameter int DRAIN_CYCLES        = DEFAULT_DRAIN_CYCLES,
  parameter int COUNTER_SIZE        = DEFAULT_COUNTER_SIZE,
  localparam int AW = $clog2(REGISTERS_BANK_SIZE)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  input  logic [AW-1:0]           i_id_rs,
  input  logic [AW-1:0]           i_id_rt,
  input  logic                    i_id_uses_rs_id,
  input  logic                    i_id_jump,
  input  logic                    i_id_halt,
  input  logic                    i_ex_mem_read,
  input  logic                    i_ex_reg_write,
  input  logic [AW-1:0]           i_ex_wr_addr,
  input  logic                    i_mem_mem_read,
  input  logic [AW-1:0]           i_mem_wr_addr,
  output logic                    o_pc_write,
  output logic                    o_if_id_write,
  output logic                    o_if_id_flush,
  output logic                    o_ctr_reg_src,
  output logic                    o_pipe_enable,
  output logic                    o_halted,
  output logic [COUNTER_SIZE-1:0] o_cycle_count,
  output logic [COUNTER_SIZE-1:0] o_stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [DW-1:0]           drain_cnt_reg, drain_cnt_next;
  logic [COUNTER_SIZE-1:0] cycle_count_reg, cycle_count_next;
  logic [COUNTER_SIZE-1:0] stall_count_reg, stall_count_next;

  logic adv;
  logic load_use;
  logic id_dep;
  logic hazard;

  assign adv = !i_step_mode || i_step;

  pipeline_ctrl_hazard_detector #(
    .REGISTERS_BANK_SIZE(REGISTERS_BANK_SIZE)
  ) u_hazard (
    .id_rs         (i_id_rs),
    .id_rt         (i_id_rt),
    .id_uses_rs_id (i_id_uses_rs_id),
    .ex_mem_read   (i_ex_mem_read),
    .ex_reg_write  (i_ex_reg_write),
    .ex_wr_addr    (i_ex_wr_addr),
    .mem_mem_read  (i_mem_mem_read),
    .mem_wr_addr   (i_mem_wr_addr),
    .load_use      (load_use),
    .id_dep        (id_dep),
    .hazard        (hazard)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg       <= ST_RUN;
      drain_cnt_reg   <= '0;
      cycle_count_reg <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      drain_cnt_reg   <= drain_cnt_next;
      cycle_count_reg <= cycle_count_next;
      stall_count_reg <= stall_count_next;
    end
  end

  // Priority: halted > freeze (~adv) > hazard > halt > jump > run.
  always_comb begin
    state_next       = state_reg;
    drain_cnt_next   = drain_cnt_reg;
    cycle_count_next = cycle_count_reg;
    stall_count_next = stall_count_reg;
    o_pc_write       = 1'b0;
    o_if_id_write    = 1'b0;
    o_if_id_flush    = 1'b0;
    o_ctr_reg_src    = 1'b0;
    o_pipe_enable    = 1'b0;
    o_halted         = 1'b0;

    if (state_reg == ST_HALTED) begin
      o_ctr_reg_src = 1'b1;
      o_halted      = 1'b1;
    end else if (adv) begin
      cycle_count_next = cycle_count_reg + COUNTER_SIZE'(1);
      o_pipe_enable    = 1'b1;
      case (state_reg)
        ST_RUN: begin
          if (hazard) begin
            // Hold PC and IF/ID, inject a bubble; a pending jump or halt is
            // seen again once the operand is available.
            o_ctr_reg_src    = 1'b1;
            stall_count_next = stall_count_reg + COUNTER_SIZE'(1);
          end else if (i_id_halt) begin
            // Let the halt itself flow down the pipe but fetch nothing more.
            state_next     = ST_DRAIN;
            drain_cnt_next = '0;
          end else if (i_id_jump) begin
            o_pc_write    = 1'b1;
            o_if_id_flush = 1'b1;
          end else begin
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
          end
        end
        ST_DRAIN: begin
          o_ctr_reg_src = 1'b1;
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_next     = ST_HALTED;
            drain_cnt_next = '0;
          end else begin
            drain_cnt_next = drain_cnt_reg + DW'(1);
          end
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  assign o_cycle_count = cycle_count_reg;
  assign o_stall_count = stall_count_reg;

endmodule
